// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache between the fetch unit and the memory controller.
// Hits answer one cycle after the request; misses fetch an 8-byte line, fill it, then answer.
module icache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic        instr_signal,
    output logic [31:0] instr_a,
    input  logic [63:0] instr_d,
    input  logic        instr_done
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 29 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic [31:0]             fetch_instr_q, fetch_instr_d;
    logic [31:0]             instr_a_q, instr_a_d;
    logic                    word_q, word_d;
    logic [TAG_BITS-1:0]     tag_mem [LINES];
    logic [63:0]             data_mem [LINES];

    logic [INDEX_BITS-1:0]   req_idx, miss_idx;
    logic [TAG_BITS-1:0]     req_tag, miss_tag;
    logic [63:0]             req_line;
    logic                    hit, fill;
    logic                    unused_ok;

    assign req_idx   = fetch_pc[3 +: INDEX_BITS];
    assign req_tag   = fetch_pc[31:3+INDEX_BITS];
    assign miss_idx  = instr_a_q[3 +: INDEX_BITS];
    assign miss_tag  = instr_a_q[31:3+INDEX_BITS];
    assign req_line  = data_mem[req_idx];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill      = (state_q == MISS) && instr_done;
    assign unused_ok = ^fetch_pc[1:0];

    // Combinational so the controller never sees a request in the cycle it signals done.
    assign instr_signal = (state_q == MISS) && !instr_done && !clear_signal;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_instr  = fetch_instr_q;
    assign instr_a      = instr_a_q;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        instr_a_d     = instr_a_q;
        word_d        = word_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_req && !clear_signal) begin
                    state_d       = hit ? RESP : MISS;
                    fetch_valid_d = hit;
                    fetch_instr_d = hit ? (fetch_pc[2] ? req_line[63:32] : req_line[31:0]) : fetch_instr_q;
                    instr_a_d     = hit ? instr_a_q : {fetch_pc[31:3], 3'b000};
                    word_d        = hit ? word_q : fetch_pc[2];
                end
            end
            MISS: begin
                // A done coinciding with a flush still carries the right line, so keep it.
                if (instr_done) begin
                    valid_d[miss_idx] = 1'b1;
                    state_d           = clear_signal ? IDLE : RESP;
                    fetch_valid_d     = !clear_signal;
                    fetch_instr_d     = clear_signal ? fetch_instr_q : (word_q ? instr_d[63:32] : instr_d[31:0]);
                end else if (clear_signal) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            instr_a_q     <= '0;
            word_q        <= 1'b0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            instr_a_q     <= instr_a_d;
            word_q        <= word_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= instr_d;
        end
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache that sits between the instruction-fetch unit and the memory controller's instruction port.
- It is the requester on that port: it drives instr_signal/instr_a, consumes the 64-bit two-instruction line (instr_d) and the instr_done pulse, and honours clear_signal (misprediction flush).
- Hits return an instruction one cycle after the request.
- Misses fetch an 8-byte aligned line, fill the cache, then respond.

Parameters:
INDEX_BITS, 6, number of line-index bits; 2^INDEX_BITS lines of 64 bits each (default 512 B).

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  ready; low freezes all state
clear_signal  input  1  misprediction flush, abandons current request
fetch_req  input  1  fetch unit requests instruction at fetch_pc
fetch_pc  input  32  instruction address; bits [1:0] ignored
fetch_valid  output  1  one-cycle pulse: fetch_instr valid for the accepted request
fetch_instr  output  32  returned instruction
instr_signal  output  1  line-fetch request to memory controller
instr_a  output  32  line address, always {pc[31:3],3'b000}
instr_d  input  64  fetched line; byte k of line at bits [8k+7:8k]
instr_done  input  1  one-cycle pulse: instr_d valid

Behaviour:
- Address split:
  - word select = pc[2]
  - index = pc[3+INDEX_BITS-1:3]
  - tag = pc[31:3+INDEX_BITS]
  - Storage per line: valid bit, tag, 64-bit data; word 0 = data[31:0], word 1 = data[63:32].
- Reset (rst_in high at clock edge, highest priority, also mid-miss):
  - all valid bits = 0, state = IDLE
  - fetch_valid = 0, fetch_instr = 0, instr_a = 0
  - instr_signal = 0 in the following cycle
- rdy_in low: no state, register or storage changes. instr_signal holds its value (the controller ignores it while paused).
- States: IDLE, MISS, RESP.
- IDLE:
  - fetch_req & ~clear_signal, hit: fetch_valid<=1, fetch_instr<=selected word → RESP.
  - fetch_req & ~clear_signal, miss: latch line address into instr_a → MISS.
  - Otherwise stay in IDLE. fetch_valid<=0 every cycle not explicitly setting it.
- MISS:
  - instr_signal = (state==MISS) & ~instr_done & ~clear_signal. This is combinational, so the controller (which re-samples instr_signal in the cycle it presents instr_done) never starts a duplicate fetch.
  - instr_done & ~clear_signal: write line (valid=1, tag, instr_d), fetch_valid<=1, fetch_instr<=word from instr_d selected by latched pc[2] → RESP.
  - clear_signal & ~instr_done: controller aborts without done; return to IDLE, no fill, no fetch_valid.
  - clear_signal & instr_done in the same cycle: fill the line (data is correct for instr_a), no fetch_valid → IDLE.
- RESP: one cycle, no request accepted (the requester is still seeing the fetch_valid edge); → IDLE. clear_signal in RESP has no extra effect.
- Requester holds fetch_req/fetch_pc stable until fetch_valid or until it asserts clear_signal; the latched pc is used during MISS.
- Latency:
  - hit: fetch_valid one cycle after the request cycle
  - miss: one cycle after instr_done (about 11 cycles with the current controller)
  - throughput: at most one instruction per 2 cycles
- Fill and lookup never happen in the same cycle; no bypass is needed.
- No write-through or invalidation port. Self-modifying code is unsupported.

Test Plan:
- Reset, mem 0x0..0x7 = 13 00 50 00 93 00 10 00, request pc=0x4 → instr_signal high with instr_a=0x0; on instr_done, fetch_valid next cycle with fetch_instr=0x00100093.
- Then request pc=0x0 → fetch_valid exactly 1 cycle later with fetch_instr=0x00500013, instr_signal stays 0.
- INDEX_BITS=6: fill pc=0x0, then pc=0x200 (same index) → miss, instr_a=0x200. Then pc=0x0 → miss again (evicted).
- Miss on pc=0x40 with clear_signal asserted mid-fetch → no fetch_valid, instr_signal low from that cycle; re-request pc=0x40 → new miss.
- clear_signal coincident with instr_done for pc=0x80 → no fetch_valid; next request pc=0x84 hits with 1-cycle latency.
- rdy_in low for 5 cycles during MISS and during RESP → state, fetch_valid and instr_a unchanged; completion resumes normally. rst_in mid-MISS → instr_signal 0 next cycle, previously filled lines miss afterwards.
